fifo_wr_arbiter: RTL and testbench

//  Round-robin burst arbiter sharing the single write port of the synchronous FIFO
//  (FIFO_SYN) among NUM_REQ producers.

---
 rtl/fifo_pkg.sv | 7 +
 rtl/rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 82 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants for the FIFO write-port arbiter
package fifo_pkg;
    localparam int FIFO_WIDTH = 32;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin winner select, searching upward from last+1 modulo NUM_REQ
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_W-1:0]   last,
    output logic [REQ_W-1:0]   winner,
    output logic               found
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit is written last and wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (req[idx]) begin
                winner = REQ_W'(idx);
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the single FIFO write port
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int REQ_W      = 2,
    parameter int BURST_LEN  = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic [FIFO_WIDTH-1:0]         din,
    output logic                          wen_a,
    output logic [REQ_W-1:0]              grant_id,
    output logic                          busy
);
    import fifo_pkg::*;

    logic                  state, state_nxt;
    logic [REQ_W-1:0]      owner, winner;
    logic [CNT_W-1:0]      beat_cnt;
    logic [FIFO_WIDTH-1:0] din_q, owner_data;
    logic                  found, xfer, last_beat, rel, take;

    rr_pick #(.NUM_REQ(NUM_REQ), .REQ_W(REQ_W)) u_pick (
        .req    (req_valid),
        .last   (owner),
        .winner (winner),
        .found  (found)
    );

    assign owner_data = req_data[owner*FIFO_WIDTH +: FIFO_WIDTH];
    assign xfer       = (state == ST_GRANT) && req_valid[owner] && !full;
    assign last_beat  = xfer && (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign rel        = (state == ST_GRANT) && (last_beat || !req_valid[owner]);
    // A new owner is taken either from IDLE or on release, with no bubble cycle.
    assign take       = found && ((state == ST_IDLE) || rel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (found) state_nxt = ST_GRANT;
            ST_GRANT: if (rel && !found) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if ((state == ST_GRANT) && !full) req_ready[owner] = 1'b1;
        wen_a    = xfer;
        din      = xfer ? owner_data : din_q;
        grant_id = owner;
        busy     = (state == ST_GRANT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= REQ_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            din_q    <= '0;
        end else begin
            if (take) begin
                owner    <= winner;
                beat_cnt <= '0;
            end else if (rel) begin
                beat_cnt <= '0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (xfer) din_q <= owner_data;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a behavioural 45-deep FIFO
module tb_fifo_wr_arbiter;
    localparam int W = 32, N = 4, RW = 2, BL = 8, CW = 8, DEPTH = 45;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           full = 1'b0;
    logic [W-1:0]   din;
    logic           wen_a;
    logic [RW-1:0]  grant_id;
    logic           busy;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .REQ_W(RW), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .full(full), .din(din), .wen_a(wen_a), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [W-1:0] src_q[N][$];
    logic [W-1:0] exp_q[N][$];
    logic [W-1:0] fifo_q[$];
    int glog[$];
    int tlog[$];
    logic [N-1:0] acc = '0;
    bit force_full = 0, rd_en = 0;
    int cyc = 0, wcnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += src_q[i].size() + exp_q[i].size();
        return s;
    endfunction

    task automatic send(input int p, input int n, input int base);
        logic [W-1:0] v;
        for (int k = 0; k < n; k++) begin
            v = W'(base + k);
            src_q[p].push_back(v);
            exp_q[p].push_back(v);
        end
    endtask

    task automatic wait_drain(input string tag);
        int b = 0;
        while ((pending() > 0 || busy) && b < 3000) begin
            @(posedge clk); #2;
            b++;
        end
        check_eq({tag, "_drain_in_time"}, b < 3000, 1);
    endtask

    task automatic clear_logs();
        glog.delete(); tlog.delete(); fifo_q.delete(); wcnt = 0;
    endtask

    // Output monitor: sampled on the falling edge, scoreboard popped per written beat.
    initial forever begin
        @(negedge clk);
        cyc++;
        acc = '0;
        if (!rst) begin
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) acc[i] = 1'b1;
            if (busy) check_eq("ready_onehot", $onehot0(req_ready), 1);
            if (full) begin
                check_eq("full_ready", req_ready, 0);
                check_eq("full_wen", wen_a, 0);
            end
            if (wen_a) begin
                check_eq("wen_busy", busy, 1);
                check_eq("wen_ready_match", acc, 32'(1) << grant_id);
                check_eq("beat_expected", exp_q[grant_id].size() > 0, 1);
                if (exp_q[grant_id].size() > 0) check_eq("din", din, exp_q[grant_id].pop_front());
                fifo_q.push_back(din);
                glog.push_back(int'(grant_id));
                tlog.push_back(cyc);
                wcnt++;
            end else if (acc != '0) begin
                check_eq("ready_without_wen", acc, 0);
            end
        end
    end

    // Producer and FIFO driver, updated just after each rising edge.
    initial forever begin
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        acc = '0;
        if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
        full = force_full || (fifo_q.size() >= DEPTH);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = src_q[i].size() > 0;
            req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int b;
        int e1[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int e5[6] = '{1, 1, 3, 3, 0, 2};

        // 1: reset held with every producer requesting
        for (int p = 0; p < N; p++) send(p, 2, 32'h0001_0000 + p * 256);
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_wen", wen_a, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant_id", grant_id, 3);
        check_eq("rst_din", din, 0);
        clear_logs();
        rst = 1'b0;
        @(negedge clk);
        check_eq("arb_latency_wen", wen_a, 0);
        check_eq("arb_latency_busy", busy, 0);
        @(posedge clk); #2;
        check_eq("first_busy", busy, 1);
        check_eq("first_grant", grant_id, 0);
        wait_drain("t1");
        check_eq("t1_beats", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) check_eq("t1_order", glog[k], e1[k]);

        // 2: single producer, 20 beats across back-to-back regrants
        clear_logs();
        send(2, 20, 0);
        wait_drain("t2");
        check_eq("t2_beats", glog.size(), 20);
        for (int k = 0; k < glog.size(); k++) check_eq("t2_owner", glog[k], 2);
        if (tlog.size() == 20) check_eq("t2_no_gap", tlog[19] - tlog[0], 19);
        for (int k = 0; k < fifo_q.size(); k++) check_eq("t2_fifo_order", fifo_q[k], k);

        // 3: two producers continuously valid
        clear_logs();
        send(0, 16, 32'h0003_0000);
        send(1, 16, 32'h0003_1000);
        wait_drain("t3");
        check_eq("t3_beats", glog.size(), 32);
        for (int k = 0; k < glog.size(); k++) check_eq("t3_burst_order", glog[k], (k / 8) % 2);

        // 4: full forced for 5 cycles after beat 3
        clear_logs();
        send(0, 8, 32'h0004_0000);
        send(1, 8, 32'h0004_1000);
        b = 0;
        while (wcnt < 3 && b < 200) begin @(negedge clk); #1; b++; end
        check_eq("t4_reach_beat3", wcnt, 3);
        @(posedge clk); #2;
        force_full = 1; full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check_eq("t4_stall_wen", wen_a, 0);
            check_eq("t4_stall_din", din, 32'h0004_0002);
        end
        @(posedge clk); #2;
        force_full = 0; full = 1'b0;
        check_eq("t4_beats_at_release", wcnt, 3);
        wait_drain("t4");
        check_eq("t4_beats", glog.size(), 16);
        for (int k = 0; k < glog.size(); k++) check_eq("t4_owner", glog[k], k < 8 ? 0 : 1);

        // 5: valid drop hands over to 3, then search restarts at 0
        clear_logs();
        send(0, 1, 32'h0005_0f00);
        wait_drain("t5_pre");
        clear_logs();
        send(1, 2, 32'h0005_1000);
        send(3, 2, 32'h0005_3000);
        send(0, 1, 32'h0005_0000);
        b = 0;
        while (!(busy && grant_id == 3) && b < 200) begin @(posedge clk); #2; b++; end
        check_eq("t5_grant3_seen", b < 200, 1);
        send(2, 1, 32'h0005_2000);
        wait_drain("t5");
        check_eq("t5_beats", glog.size(), 6);
        for (int k = 0; k < 6 && k < glog.size(); k++) check_eq("t5_order", glog[k], e5[k]);
        if (tlog.size() >= 3) check_eq("t5_handover_cycles", tlog[2] - tlog[1], 2);

        // 6: reset mid-burst, then fill the FIFO past FULL
        clear_logs();
        send(2, 10, 32'h0006_2000);
        b = 0;
        while (wcnt < 4 && b < 200) begin @(negedge clk); #1; b++; end
        check_eq("t6_reach_beat4", wcnt, 4);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_eq("t6_async_wen", wen_a, 0);
        check_eq("t6_async_ready", req_ready, 0);
        check_eq("t6_async_busy", busy, 0);
        check_eq("t6_async_grant", grant_id, 3);
        check_eq("t6_async_din", din, 0);
        send(0, 15, 32'h0006_0000);
        send(1, 15, 32'h0006_1000);
        send(3, 15, 32'h0006_3000);
        @(posedge clk); #2;
        glog.delete(); tlog.delete();
        rst = 1'b0;
        @(posedge clk); #2;
        check_eq("t6_restart_busy", busy, 1);
        check_eq("t6_restart_grant", grant_id, 0);
        b = 0;
        while (!full && b < 500) begin @(posedge clk); #2; b++; end
        check_eq("t6_full_seen", full, 1);
        repeat (10) @(posedge clk);
        #2;
        check_eq("t6_fifo_level", fifo_q.size(), DEPTH);
        rd_en = 1;
        wait_drain("t6");
        rd_en = 0;
        check_eq("t6_total_beats", wcnt, 55);
        check_eq("scoreboard_empty", pending(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
